// File: rtl/seq_divider_4bit.sv
// Sequential unsigned restoring divider: one quotient bit per clock, WIDTH cycles busy,
// then a one-cycle done pulse with registered quotient/remainder/div_by_zero.
module seq_divider_4bit #(
    parameter int WIDTH = 4
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             start_i,
    input  logic [WIDTH-1:0] dividend_i,
    input  logic [WIDTH-1:0] divisor_i,
    output logic             busy_o,
    output logic             done_o,
    output logic [WIDTH-1:0] quotient_o,
    output logic [WIDTH-1:0] remainder_o,
    output logic             div_by_zero_o
);

    localparam int CW = $clog2(WIDTH) + 1;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH:0]   r_q, r_d;
    logic [WIDTH-1:0] q_q, q_d;
    logic [WIDTH-1:0] d_q, d_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             zf_q, zf_d;
    logic [WIDTH-1:0] quot_q, quot_d;
    logic [WIDTH-1:0] rem_q, rem_d;
    logic             dbz_q, dbz_d;

    logic [WIDTH:0]   shifted;
    logic [WIDTH:0]   trial;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= S_IDLE;
            r_q     <= '0;
            q_q     <= '0;
            d_q     <= '0;
            cnt_q   <= '0;
            zf_q    <= 1'b0;
            quot_q  <= '0;
            rem_q   <= '0;
            dbz_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            r_q     <= r_d;
            q_q     <= q_d;
            d_q     <= d_d;
            cnt_q   <= cnt_d;
            zf_q    <= zf_d;
            quot_q  <= quot_d;
            rem_q   <= rem_d;
            dbz_q   <= dbz_d;
        end
    end

    always_comb begin
        state_d = state_q;
        r_d     = r_q;
        q_d     = q_q;
        d_d     = d_q;
        cnt_d   = cnt_q;
        zf_d    = zf_q;
        quot_d  = quot_q;
        rem_d   = rem_q;
        dbz_d   = dbz_q;

        // Bring down the next dividend bit, then try subtracting the divisor.
        shifted = {r_q[WIDTH-1:0], q_q[WIDTH-1]};
        trial   = shifted - {1'b0, d_q};

        case (state_q)
            S_IDLE, S_DONE: begin
                state_d = S_IDLE;
                if (start_i) begin
                    state_d = S_RUN;
                    q_d     = dividend_i;
                    d_d     = divisor_i;
                    r_d     = '0;
                    cnt_d   = '0;
                    zf_d    = (divisor_i == '0);
                end
            end
            S_RUN: begin
                if (!trial[WIDTH]) begin
                    r_d = trial;
                    q_d = {q_q[WIDTH-2:0], 1'b1};
                end else begin
                    r_d = shifted;
                    q_d = {q_q[WIDTH-2:0], 1'b0};
                end
                cnt_d = cnt_q + CW'(1);
                // Results are latched together with the final iteration.
                if (cnt_q == CW'(WIDTH - 1)) begin
                    state_d = S_DONE;
                    quot_d  = q_d;
                    rem_d   = r_d[WIDTH-1:0];
                    dbz_d   = zf_q;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    assign busy_o        = (state_q == S_RUN);
    assign done_o        = (state_q == S_DONE);
    assign quotient_o    = quot_q;
    assign remainder_o   = rem_q;
    assign div_by_zero_o = dbz_q;

endmodule
